// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and latency-counter sizing for mem_port_arbiter.
package mem_arb_pkg;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
    typedef enum logic {GNT_IF, GNT_DM} grant_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (IF/DM), pipeline-stall and RAM-port signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
    );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter timing the memory latency; flags the last count and zero.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             last_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i) cnt_q <= cnt_q - 1'b1;
    end

    assign last_o = (cnt_q == CNT_W'(1));
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch (IF) and memory (DM) stages.
// Define MEM_ARB_PERF_CNT_EN to add saturating stall/fetch/data performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic p_clk,
    input  logic p_rst_s,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_dm_cnt
`endif
);
    arb_state_e        state_q;
    grant_e            gnt_q, last_q, win;
    logic              if_valid_q, dm_valid_q, mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
    logic              cnt_last, cnt_zero, lat_done;

    // DM has priority unless it was served last while IF is waiting
    assign win = (bus.dm_req && (!bus.if_req || last_q != GNT_DM)) ? GNT_DM : GNT_IF;
    assign lat_done = (MEM_LAT == 1) ? (state_q == ISSUE) : (state_q == WAIT && cnt_last);

    mem_lat_counter u_cnt (
        .clk   (p_clk),
        .rst_n (p_rst_s),
        .load_i(state_q == ISSUE),
        .val_i (CNT_W'(MEM_LAT - 1)),
        .dec_i (state_q == WAIT && !cnt_zero),
        .last_o(cnt_last),
        .zero_o(cnt_zero)
    );

    always_ff @(posedge p_clk) begin
        if (!p_rst_s) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            last_q      <= GNT_IF;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            mem_en_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.if_req || bus.dm_req) begin
                    state_q     <= ISSUE;
                    mem_en_q    <= 1'b1;
                    gnt_q       <= win;
                    mem_addr_q  <= (win == GNT_DM) ? bus.dm_addr : bus.if_addr;
                    mem_we_q    <= (win == GNT_DM) && bus.dm_we;
                    mem_wdata_q <= (win == GNT_DM) ? bus.dm_wdata : '0;
                end
                ISSUE: begin
                    last_q  <= gnt_q;
                    state_q <= (MEM_LAT == 1) ? DONE : WAIT;
                end
                WAIT: if (cnt_last) state_q <= DONE;
                DONE: state_q <= IDLE;
            endcase
            if (lat_done) begin
                if_valid_q <= (gnt_q == GNT_IF);
                dm_valid_q <= (gnt_q == GNT_DM);
                if (gnt_q == GNT_IF) if_rdata_q <= bus.mem_rdata;
                else if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_valid   = if_valid_q;
    assign bus.dm_valid   = dm_valid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    // in DONE only the losing requester can still need the pipeline held
    assign bus.pipe_stall = (state_q == DONE) ? ((gnt_q == GNT_DM) ? bus.if_req : bus.dm_req)
                                              : (bus.if_req || bus.dm_req);

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_q, ifc_q, dmc_q;

    always_ff @(posedge p_clk) begin
        if (!p_rst_s) begin
            stall_q <= '0;
            ifc_q   <= '0;
            dmc_q   <= '0;
        end else begin
            if (bus.pipe_stall && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (if_valid_q && !(&ifc_q)) ifc_q <= ifc_q + 1'b1;
            if (dm_valid_q && !(&dmc_q)) dmc_q <= dmc_q + 1'b1;
        end
    end

    assign perf_stall_cyc = stall_q;
    assign perf_if_cnt    = ifc_q;
    assign perf_dm_cnt    = dmc_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (MEM_LAT=2 main DUT, MEM_LAT=1 side DUT).
module tb_mem_port_arbiter;
    localparam logic [31:0] JUNK = 32'hBADBAD00;
    localparam logic [31:0] INSN = 32'h2002000A;

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] data;
    } sb_t;

    logic p_clk = 1'b0;
    logic p_rst_s = 1'b0;
    always #5 p_clk = ~p_clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_if_cnt, perf_dm_cnt;
    logic [31:0] perf1_stall_cyc, perf1_if_cnt, perf1_dm_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .p_clk  (p_clk),
        .p_rst_s(p_rst_s),
        .bus    (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_if_cnt   (perf_if_cnt),
        .perf_dm_cnt   (perf_dm_cnt)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .p_clk  (p_clk),
        .p_rst_s(p_rst_s),
        .bus    (bus1)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_stall_cyc(perf1_stall_cyc),
        .perf_if_cnt   (perf1_if_cnt),
        .perf_dm_cnt   (perf1_dm_cnt)
`endif
    );

    logic [31:0] tb_ram [256];
    logic [31:0] ram1 [256];
    logic [31:0] exp_mem [256];
    logic [31:0] rd_q;
    sb_t         exp_q [$];
    sb_t         sb;
    logic [31:0] last_dm;
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;

    int          lat, en, sh;
    logic        we_s;
    logic [31:0] ea;

    // RAM model: read data appears one cycle after the strobe, i.e. two cycles of latency incl. issue
    always @(posedge p_clk) begin
        if (bus.mem_en && bus.mem_we) tb_ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rd_q <= (bus.mem_en && !bus.mem_we) ? tb_ram[bus.mem_addr[7:0]] : JUNK;
    end
    assign bus.mem_rdata  = rd_q;
    assign bus1.mem_rdata = bus1.mem_en ? ram1[bus1.mem_addr[7:0]] : JUNK;

    always @(negedge p_clk) begin
        if (!p_rst_s) begin
            exp_q.delete();
            last_dm = '0;
            stall_cnt = 0;
        end else begin
            if (bus.pipe_stall) stall_cnt++;
            if (bus.if_valid || bus.dm_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: if_valid=%0b dm_valid=%0b, required no valid", bus.if_valid, bus.dm_valid);
                end else begin
                    sb = exp_q.pop_front();
                    if ({bus.dm_valid, bus.if_valid} !== {sb.is_dm, !sb.is_dm}) begin
                        errors++;
                        $display("FAIL sb_port: dm_valid/if_valid=%b, required %b", {bus.dm_valid, bus.if_valid}, {sb.is_dm, !sb.is_dm});
                    end else if (sb.is_dm && sb.we) begin
                        if (bus.dm_rdata !== last_dm) begin
                            errors++;
                            $display("FAIL sb_store_rdata: dm_rdata=%h, required unchanged %h", bus.dm_rdata, last_dm);
                        end
                    end else if (sb.is_dm) begin
                        if (bus.dm_rdata !== sb.data) begin
                            errors++;
                            $display("FAIL sb_load: dm_rdata=%h, required %h", bus.dm_rdata, sb.data);
                        end
                        last_dm = sb.data;
                    end else if (bus.if_rdata !== sb.data) begin
                        errors++;
                        $display("FAIL sb_fetch: if_rdata=%h, required %h", bus.if_rdata, sb.data);
                    end
                end
            end
        end
    end

    task automatic access(input logic dm, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int n, output int en_cnt, output logic we_seen, output logic [31:0] en_addr,
                          output int stall_hi);
        sb_t  e;
        logic got;
        @(negedge p_clk);
        e.is_dm = dm;
        e.we = we;
        e.data = exp_mem[addr[7:0]];
        if (dm && we) exp_mem[addr[7:0]] = wd;
        exp_q.push_back(e);
        if (dm) begin
            bus.dm_req = 1'b1;
            bus.dm_we = we;
            bus.dm_addr = addr;
            bus.dm_wdata = wd;
        end else begin
            bus.if_req = 1'b1;
            bus.if_addr = addr;
        end
        n = 0; en_cnt = 0; we_seen = 1'b0; en_addr = '0; stall_hi = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge p_clk);
            n++;
            if (bus.mem_en) begin
                en_cnt++;
                we_seen = bus.mem_we;
                en_addr = bus.mem_addr;
            end
            if (bus.pipe_stall) stall_hi++;
            got = dm ? bus.dm_valid : bus.if_valid;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL access_timeout: no valid after %0d cycles for addr %h, required one", n, addr);
        end
    endtask

    task automatic test_reset();
        p_rst_s = 1'b0;
        repeat (2) @(negedge p_clk);
        checks++;
        if ({bus.if_valid, bus.dm_valid, bus.mem_en, bus.mem_we, bus.pipe_stall} !== 5'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h if_rdata=%h dm_rdata=%h, required all 0",
                     {bus.if_valid, bus.dm_valid, bus.mem_en, bus.mem_we, bus.pipe_stall}, bus.mem_addr,
                     bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
        end
        checks++;
        if ({bus1.if_valid, bus1.dm_valid, bus1.mem_en, bus1.mem_we} !== 4'b0 || bus1.mem_addr !== '0 || bus1.if_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1: ctl=%b addr=%h if_rdata=%h, required all 0",
                     {bus1.if_valid, bus1.dm_valid, bus1.mem_en, bus1.mem_we}, bus1.mem_addr, bus1.if_rdata);
        end
        p_rst_s = 1'b1;
    endtask

    task automatic test_single_fetch();
        access(1'b0, 1'b0, 32'h10, 32'h0, lat, en, we_s, ea, sh);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL fetch_latency: %0d cycles, required 3", lat); end
        checks++;
        if (en !== 1 || ea !== 32'h10) begin errors++; $display("FAIL fetch_strobe: mem_en cycles=%0d addr=%h, required 1 and 00000010", en, ea); end
        checks++;
        if (sh !== 2) begin errors++; $display("FAIL fetch_stall: stall cycles=%0d, required 2", sh); end
        checks++;
        if (bus.if_rdata !== INSN) begin errors++; $display("FAIL fetch_data: if_rdata=%h, required %h", bus.if_rdata, INSN); end
    endtask

    task automatic test_store_load();
        access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, lat, en, we_s, ea, sh);
        checks++;
        if (en !== 1 || we_s !== 1'b1 || ea !== 32'h40 || lat !== 3) begin
            errors++;
            $display("FAIL store_strobe: en=%0d we=%b addr=%h lat=%0d, required 1 1 00000040 3", en, we_s, ea, lat);
        end
        access(1'b1, 1'b0, 32'h40, 32'h0, lat, en, we_s, ea, sh);
        checks++;
        if (we_s !== 1'b0 || lat !== 3) begin errors++; $display("FAIL load_strobe: we=%b lat=%0d, required 0 3", we_s, lat); end
        checks++;
        if (bus.dm_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: dm_rdata=%h, required deadbeef", bus.dm_rdata); end
        checks++;
        if (bus.if_rdata !== INSN) begin errors++; $display("FAIL load_if_hold: if_rdata=%h, required %h", bus.if_rdata, INSN); end
    endtask

    task automatic test_contention();
        sb_t e;
        int  c, prev, n;
        p_rst_s = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
        repeat (2) @(negedge p_clk);
        p_rst_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.is_dm = (i % 2 == 0);
            e.we = 1'b0;
            e.data = e.is_dm ? exp_mem[8'h40] : exp_mem[8'h10];
            exp_q.push_back(e);
        end
        c = 0; prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge p_clk);
                c++; n++;
            end while (!(bus.if_valid || bus.dm_valid) && n < 20);
            checks++;
            if (bus.dm_valid !== (k % 2 == 0) || bus.if_valid !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL contention_grant%0d: dm_valid=%b if_valid=%b, required dm=%0d", k, bus.dm_valid, bus.if_valid, k % 2 == 0);
            end
            checks++;
            if (c - prev !== ((k == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL contention_spacing%0d: %0d cycles, required %0d", k, c - prev, (k == 0) ? 3 : 4);
            end
            checks++;
            if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL contention_stall%0d: pipe_stall=%b, required 1", k, bus.pipe_stall); end
            prev = c;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nv;
        @(negedge p_clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h20;
        repeat (2) @(negedge p_clk);
        p_rst_s = 1'b0;
        bus.if_req = 1'b0;
        @(negedge p_clk);
        checks++;
        if ({bus.if_valid, bus.dm_valid, bus.mem_en, bus.mem_we, bus.pipe_stall} !== 5'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ctl=%b addr=%h wdata=%h if_rdata=%h dm_rdata=%h, required all 0",
                     {bus.if_valid, bus.dm_valid, bus.mem_en, bus.mem_we, bus.pipe_stall}, bus.mem_addr,
                     bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
        end
        p_rst_s = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge p_clk);
            if (bus.if_valid || bus.dm_valid) nv++;
        end
        checks++;
        if (nv !== 0) begin errors++; $display("FAIL midreset_novalid: %0d valid pulses, required 0", nv); end
        access(1'b0, 1'b0, 32'h20, 32'h0, lat, en, we_s, ea, sh);
        checks++;
        if (lat !== 3 || bus.if_rdata !== exp_mem[8'h20]) begin
            errors++;
            $display("FAIL midreset_refetch: lat=%0d if_rdata=%h, required 3 %h", lat, bus.if_rdata, exp_mem[8'h20]);
        end
    endtask

    task automatic test_lat1();
        int n, e1;
        @(negedge p_clk);
        bus1.if_req = 1'b1;
        bus1.if_addr = 32'h10;
        n = 0; e1 = 0;
        do begin
            @(negedge p_clk);
            n++;
            if (bus1.mem_en) e1++;
        end while (!bus1.if_valid && n < 20);
        bus1.if_req = 1'b0;
        checks++;
        if (n !== 2 || e1 !== 1) begin errors++; $display("FAIL lat1_timing: valid after %0d cycles, %0d strobes, required 2 and 1", n, e1); end
        checks++;
        if (bus1.if_rdata !== INSN) begin errors++; $display("FAIL lat1_data: if_rdata=%h, required %h", bus1.if_rdata, INSN); end
    endtask

    task automatic test_back_to_back();
        logic        dm, we;
        logic [31:0] addr, wd;
        for (int i = 0; i < 12; i++) begin
            dm = 1'($urandom_range(0, 1));
            we = dm & 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            wd = $urandom;
            access(dm, we, addr, wd, lat, en, we_s, ea, sh);
            checks++;
            if (lat !== 3 || en !== 1 || we_s !== we || ea !== addr) begin
                errors++;
                $display("FAIL b2b%0d: lat=%0d en=%0d we=%b addr=%h, required 3 1 %b %h", i, lat, en, we_s, ea, we, addr);
            end
        end
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf();
        p_rst_s = 1'b0;
        repeat (2) @(negedge p_clk);
        p_rst_s = 1'b1;
        access(1'b0, 1'b0, 32'h10, 32'h0, lat, en, we_s, ea, sh);
        access(1'b0, 1'b0, 32'h20, 32'h0, lat, en, we_s, ea, sh);
        access(1'b0, 1'b0, 32'h30, 32'h0, lat, en, we_s, ea, sh);
        access(1'b1, 1'b0, 32'h40, 32'h0, lat, en, we_s, ea, sh);
        access(1'b1, 1'b0, 32'h50, 32'h0, lat, en, we_s, ea, sh);
        @(negedge p_clk);
        checks++;
        if (perf_if_cnt !== 32'd3) begin errors++; $display("FAIL perf_if: %0d, required 3", perf_if_cnt); end
        checks++;
        if (perf_dm_cnt !== 32'd2) begin errors++; $display("FAIL perf_dm: %0d, required 2", perf_dm_cnt); end
        checks++;
        if (perf_stall_cyc !== 32'(stall_cnt)) begin errors++; $display("FAIL perf_stall: %0d, required %0d", perf_stall_cyc, stall_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = (i == 16) ? INSN : (32'hC0DE0000 | 32'(i * 7));
            ram1[i] = exp_mem[i];
            tb_ram[i] <= exp_mem[i];
        end
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_lat1();
        test_back_to_back();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        repeat (2) @(negedge p_clk);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_drain: %0d entries outstanding, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
